branch_prediction_checker: RTL
==============================

// Module: branch_prediction_checker
// PURPOSE
//  Verifying end of the BTB prediction path: queues every prediction issued at IF, then checks it
//  against the resolved control flow from EXEC. Raises flush/redirect on mispredict and produces the
//  BTB write-back request (current/next address) so the BTB stays coherent with resolved branches.
//  Sits between the IF-stage BTB lookup and the EXEC-stage branch resolution.
// PARAMETERS
//  DEPTH  8  max in-flight predictions; power of 2, >= 2
// PORTS
//  clk_i               in   1   clock; all state updates on posedge
//  arst_i              in   1   async reset, active-high
//  pred_valid_i        in   1   IF issues a prediction this cycle
//  pred_ready_o        out  1   queue accepts prediction (= ~full & ~flush_o)
//  pred_pc_i           in   64  fetched pc
//  pred_next_pc_i      in   64  predicted next pc (BTB target, or pc+4 if no hit)
//  pred_taken_i        in   1   BTB hit for pred_pc_i
//  res_valid_i         in   1   EXEC resolves oldest instruction
//  res_ready_o         out  1   queue head available (= ~empty)
//  res_current_addr_i  in   64  resolved instruction address
//  res_next_addr_i     in   64  actual next address
//  res_is_jump_i       in   1   resolved instruction is jump/branch
//  flush_o             out  1   registered 1-cycle pulse: mispredict, squash younger work
//  redirect_pc_o       out  64  correct pc, valid with flush_o
//  upd_valid_o         out  1   registered 1-cycle BTB update request
//  upd_current_addr_o  out  64  address to write in BTB
//  upd_next_addr_o     out  64  target to write in BTB
//  occupancy_o         out  $clog2(DEPTH)+1  entries in queue
// BEHAVIOUR
//  - Reset (arst_i=1, any time, incl. mid-operation): queue empty, pointers 0, all outputs 0;
//    in-flight entries discarded, no flush/update emitted for them.
//  - Queue: circular FIFO of {pc, next_pc, taken}; rd/wr pointers $clog2(DEPTH)+1 bits, MSB marks
//    wrap; full = ptr MSBs differ & low bits equal; empty = pointers equal. No bypass: a prediction
//    pushed in cycle N is resolvable from N+1.
//  - Push on pred_valid_i & pred_ready_o; pop on res_valid_i & res_ready_o. Push and pop in the same
//    cycle are legal at any occupancy where both readies are high; occupancy unchanged.
//  - Check on pop: mispredict = head.next_pc != res_next_addr_i. Next cycle: flush_o=1,
//    redirect_pc_o=res_next_addr_i. 1-cycle latency, outputs registered.
//  - Flush cycle (flush_o=1): entire queue cleared (younger predictions are wrong-path);
//    pred_ready_o=0, res_ready_o=0; a push offered in that cycle is dropped.
//    Queue refills from the following cycle.
//  - Update: taken_actual = (res_current_addr_i + 64'd4 != res_next_addr_i), wrapping 64-bit add.
//    upd_valid_o next cycle = res_is_jump_i & (taken_actual ^ head.taken); addresses registered
//    from res_*. Non-jump pops never update. Update and flush may fire in the same cycle.
//  - res_current_addr_i != head.pc on pop: assertion error (ordering violation); entry treated
//    as mispredict.
//  - Outputs hold 0 when not pulsing; redirect_pc_o/upd_*_addr_o hold last value (don't care).
// CONFIGURATION
//  BRANCH_PRED_STATS_EN defined: adds outputs resolved_cnt_o[31:0] and mispredict_cnt_o[31:0].
//    Increment per pop and per mispredict, saturate at 32'hFFFF_FFFF, cleared by arst_i only.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  - Reset: arst_i pulse mid-traffic with 3 entries -> occupancy_o=0, flush_o=0, upd_valid_o=0.
//  - Correct hit: push pc=0x1000 next=0x2000 taken=1; resolve cur=0x1000 next=0x2000 jump=1
//    -> no flush, no update, occupancy 1->0.
//  - Mispredict: push pc=0x1000 next=0x1004 taken=0, plus 2 younger entries; resolve next=0x3000
//    jump=1 -> next cycle flush_o=1, redirect_pc_o=0x3000, upd_valid_o=1 (0x1000->0x3000),
//    occupancy_o=0.
//  - Full/wrap: push DEPTH entries -> pred_ready_o=0; pop 1 + push 1 same cycle, repeat 2*DEPTH
//    -> FIFO order preserved across pointer wrap, occupancy stays DEPTH-1/DEPTH.
//  - Stale BTB entry: push taken=1 next=0x2000; resolve cur=0x1000 next=0x1004 jump=1
//    -> flush_o=1 redirect 0x1004, upd_valid_o=1 (invalidate).
//  - Stats (BRANCH_PRED_STATS_EN): 10 pops, 3 mispredicts -> resolved_cnt_o=10, mispredict_cnt_o=3.

Source files
------------

// File: rtl/branch_prediction_checker.sv
// Checks queued IF-stage BTB predictions against EXEC resolution, raising flush/redirect and BTB updates.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_prediction_checker #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     pred_valid_i,
  output logic                     pred_ready_o,
  input  logic [63:0]              pred_pc_i,
  input  logic [63:0]              pred_next_pc_i,
  input  logic                     pred_taken_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [63:0]              res_current_addr_i,
  input  logic [63:0]              res_next_addr_i,
  input  logic                     res_is_jump_i,
  output logic                     flush_o,
  output logic [63:0]              redirect_pc_o,
  output logic                     upd_valid_o,
  output logic [63:0]              upd_current_addr_o,
  output logic [63:0]              upd_next_addr_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]              resolved_cnt_o,
  output logic [31:0]              mispredict_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [63:0]      pc_mem   [DEPTH];
  logic [63:0]      next_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic             flush_q, flush_d;
  logic [63:0]      redirect_q, redirect_d;
  logic             upd_valid_q, upd_valid_d;
  logic [63:0]      upd_cur_q, upd_cur_d;
  logic [63:0]      upd_next_q, upd_next_d;

  logic             full, empty, push, pop;
  logic [63:0]      head_pc, head_next;
  logic             head_taken, order_err, mispredict, taken_actual;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign pred_ready_o = ~full & ~flush_q;
  assign res_ready_o  = ~empty & ~flush_q;

  assign push = pred_valid_i & pred_ready_o;
  assign pop  = res_valid_i & res_ready_o;

  assign head_pc    = pc_mem[rd_ptr_q[AW-1:0]];
  assign head_next  = next_mem[rd_ptr_q[AW-1:0]];
  assign head_taken = taken_mem[rd_ptr_q[AW-1:0]];

  // An out-of-order resolution cannot be trusted, so it is handled as a mispredict.
  assign order_err    = (head_pc != res_current_addr_i);
  assign mispredict   = pop & ((head_next != res_next_addr_i) | order_err);
  assign taken_actual = ((res_current_addr_i + 64'd4) != res_next_addr_i);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    flush_d     = mispredict;
    redirect_d  = redirect_q;
    upd_valid_d = pop & res_is_jump_i & (taken_actual ^ head_taken);
    upd_cur_d   = upd_cur_q;
    upd_next_d  = upd_next_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      upd_cur_d  = res_current_addr_i;
      upd_next_d = res_next_addr_i;
    end
    // Everything younger than a mispredicted branch is wrong-path, including a same-cycle push.
    if (mispredict) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      redirect_d = res_next_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_cur_q   <= '0;
      upd_next_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      upd_valid_q <= upd_valid_d;
      upd_cur_q   <= upd_cur_d;
      upd_next_q  <= upd_next_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q[AW-1:0]]    <= pred_pc_i;
      next_mem[wr_ptr_q[AW-1:0]]  <= pred_next_pc_i;
      taken_mem[wr_ptr_q[AW-1:0]] <= pred_taken_i;
    end
  end

  always @(posedge clk_i) begin
    if (!arst_i && pop) begin
      resolve_order: assert (!order_err);
    end
  end

  assign flush_o            = flush_q;
  assign redirect_pc_o      = redirect_q;
  assign upd_valid_o        = upd_valid_q;
  assign upd_current_addr_o = upd_cur_q;
  assign upd_next_addr_o    = upd_next_q;
  assign occupancy_o        = wr_ptr_q - rd_ptr_q;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] resolved_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      resolved_cnt_q   <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (pop && (resolved_cnt_q != 32'hFFFF_FFFF))
        resolved_cnt_q <= resolved_cnt_q + 32'd1;
      if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign resolved_cnt_o   = resolved_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule
